// File: rtl/aes_pkg.sv
// Shared AES-128 tables, GF(2^8) helpers and FSM state type for the decrypt datapath.
package aes_pkg;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned NR_ROUNDS = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        INIT  = 3'd2,
        ROUND = 3'd3,
        FINAL = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [WORD_W-1:0] inv_mix_column(input logic [WORD_W-1:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte b = 4*col + row sits at [127-8b -: 8]; row r rotates right by r columns.
    function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        for (int b = 0; b < 16; b++) o[8*b +: 8] = INV_SBOX[s[8*b +: 8]];
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        for (int c = 0; c < 4; c++) o[WORD_W*c +: WORD_W] = inv_mix_column(s[WORD_W*c +: WORD_W]);
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] key_expand(input logic [BLK_W-1:0] prev, input logic [7:0] rcon);
        logic [WORD_W-1:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = prev;
        t  = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/inv_round_function.sv
// One combinational AES inverse round; last_i drops InvMixColumns for the final round.
module inv_round_function
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] data_i,
    input  logic [BLK_W-1:0] key_i,
    input  logic             last_i,
    output logic [BLK_W-1:0] data_o
);

    logic [BLK_W-1:0] ark_c;

    always_comb begin
        ark_c  = inv_sub_bytes(inv_shift_rows(data_i)) ^ key_i;
        data_o = last_i ? ark_c : inv_mix_columns(ark_c);
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: on-chip key expansion then one inverse round per clock.
// Optional AES_DEC_KEY_CACHE_EN reuses the expanded schedule when the same key is presented again.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned NR    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] key_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_o,
    output logic             busy
);

    if (WIDTH != 128 || NR != 10) begin : g_param_check
        $error("aes128_decrypt_iter supports only WIDTH=128 and NR=10");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   st_q, st_d;
    logic [WIDTH-1:0]   data_o_q, data_o_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, busy_q;
    logic [WIDTH-1:0]   rk_q [0:NR];
    logic               rk_we;
    logic [CNT_W-1:0]   rk_widx;
    logic [WIDTH-1:0]   rk_wdata;
    logic [CNT_W-1:0]   kidx_c;
    logic [WIDTH-1:0]   kexp_c;
    logic [WIDTH-1:0]   irf_out_c;
    logic               accept_c;
    logic               key_hit_c;

    assign accept_c = in_valid && in_ready_q;
    assign kidx_c   = cnt_q - CNT_W'(1);
    assign kexp_c   = key_expand(rk_q[kidx_c], RCON[cnt_q]);

    inv_round_function u_irf (
        .data_i (st_q),
        .key_i  (rk_q[cnt_q]),
        .last_i (state_q == FINAL),
        .data_o (irf_out_c)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    // Valid only once a full expansion of the stored rk[0] has completed.
    logic key_cached_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_cached_q <= 1'b0;
        end else if (state_q == KEXP && cnt_q == CNT_W'(NR)) begin
            key_cached_q <= 1'b1;
        end else if (state_q == IDLE && accept_c && !key_hit_c) begin
            key_cached_q <= 1'b0;
        end
    end

    assign key_hit_c = key_cached_q && (key_i == rk_q[0]);
`else
    assign key_hit_c = 1'b0;
`endif

    // State register; in_ready/busy are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = key_hit_c ? INIT : KEXP;
            KEXP:    if (cnt_q == CNT_W'(NR)) state_d = INIT;
            INIT:    state_d = ROUND;
            ROUND:   if (cnt_q == CNT_W'(1)) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state; cnt reaches 0 entering FINAL so rk_q[cnt_q] selects rk[0] there.
    always_comb begin
        cnt_d       = cnt_q;
        st_d        = st_q;
        data_o_d    = data_o_q;
        out_valid_d = out_valid_q;
        rk_we       = 1'b0;
        rk_widx     = cnt_q;
        rk_wdata    = kexp_c;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    st_d     = data_i;
                    rk_we    = 1'b1;
                    rk_widx  = '0;
                    rk_wdata = key_i;
                    cnt_d    = key_hit_c ? '0 : CNT_W'(1);
                end
            end
            KEXP: begin
                rk_we = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            INIT: begin
                st_d  = st_q ^ rk_q[NR];
                cnt_d = CNT_W'(NR - 1);
            end
            ROUND: begin
                st_d  = irf_out_c;
                cnt_d = cnt_q - CNT_W'(1);
            end
            FINAL: begin
                st_d        = irf_out_c;
                data_o_d    = irf_out_c;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            st_q        <= '0;
            data_o_q    <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i <= int'(NR); i++) rk_q[i] <= '0;
        end else begin
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            data_o_q    <= data_o_d;
            out_valid_q <= out_valid_d;
            if (rk_we) rk_q[rk_widx] <= rk_wdata;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign data_o    = data_o_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter using FIPS-197 vectors and handshake corner cases.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_i;
    logic [127:0] key_i;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_o;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int           LAT    = 21;
    localparam int           MAX_WAIT = 60;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam int           CACHED_LAT = 11;
`else
    localparam int           CACHED_LAT = 21;
`endif

    always #5 clk = ~clk;

    aes128_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .key_i     (key_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one block for a single edge, then scrambles the inputs.
    task automatic send(input logic [127:0] ct, input logic [127:0] key);
        data_i   = ct;
        key_i    = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Counts edges until out_valid, starting from 'start'; saturates at MAX_WAIT.
    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_i = '0; key_i = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (data_o !== 128'h0) begin failures++; $display("FAIL reset_data_o got=%h want=0", data_o); end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_c1();
        int lat;
        send(C1_CT, C1_KEY);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL c1_busy got=%b/%b want=1/0", busy, in_ready); end
        wait_out(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL c1_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (data_o !== C1_PT) begin failures++; $display("FAIL c1_data got=%h want=%h", data_o, C1_PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL c1_release got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL c1_idle got=%b/%b want=1/0", in_ready, busy); end
    endtask

    task automatic test_app_b();
        int lat;
        send(B_CT, B_KEY);
        wait_out(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL appb_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (data_o !== B_PT) begin failures++; $display("FAIL appb_data got=%h want=%h", data_o, B_PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        send(C1_CT, C1_KEY);
        wait_out(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || data_o !== C1_PT || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got v=%b r=%b d=%h want v=1 r=0 d=%h", i, out_valid, in_ready, data_o, C1_PT);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle got=%b want=1", in_ready); end
    endtask

    task automatic test_busy_reject();
        int lat;
        send(C1_CT, C1_KEY);
        repeat (4) tick();
        data_i = '0; key_i = '0; in_valid = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rej_in_ready got=%b want=0", in_ready); end
        tick();
        in_valid = 1'b0;
        wait_out(5, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rej_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (data_o !== C1_PT) begin failures++; $display("FAIL rej_data got=%h want=%h", data_o, C1_PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rej_no_second got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int spurious;
        send(B_CT, B_KEY);
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_now got v=%b b=%b want 0/0", out_valid, busy); end
        checks++; if (data_o !== 128'h0) begin failures++; $display("FAIL rstmid_data got=%h want=0", data_o); end
        tick();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL rstmid_no_output got=%0d want=0", spurious); end
        send(C1_CT, C1_KEY);
        wait_out(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rstmid_c1_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (data_o !== C1_PT) begin failures++; $display("FAIL rstmid_c1_data got=%h want=%h", data_o, C1_PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_out_ready_early();
        int lat;
        out_ready = 1'b1;
        send(B_CT, B_KEY);
        wait_out(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL early_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (data_o !== B_PT) begin failures++; $display("FAIL early_data got=%h want=%h", data_o, B_PT); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL early_pulse got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        send(B_CT, B_KEY);
        wait_out(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, LAT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
        send(B_CT, B_KEY);
        wait_out(0, lat);
        checks++; if (lat !== CACHED_LAT) begin failures++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, CACHED_LAT); end
        checks++; if (data_o !== B_PT) begin failures++; $display("FAIL b2b_second_data got=%h want=%h", data_o, B_PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(C1_CT, C1_KEY);
        wait_out(0, lat);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_newkey_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (data_o !== C1_PT) begin failures++; $display("FAIL b2b_newkey_data got=%h want=%h", data_o, C1_PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_c1();
        test_app_b();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_out_ready_early();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
